// File: rtl/syn_fetch_buffer_pkg.sv
// Shared fetch-path constants. IM_ADDR_BIT mirrors the Core.vh instruction-memory width.
`ifndef IM_ADDR_BIT
`define IM_ADDR_BIT 10
`endif

package syn_fetch_buffer_pkg;
  localparam int IM_ADDR_BIT = `IM_ADDR_BIT;
  localparam int INST_BITS   = 32;
endpackage

// File: rtl/syn_fetch_fifo.sv
// Circular fetch queue. The head entry is read combinationally; flush wins over push/pop.
module syn_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW:0]      count;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  // Storage is deliberately left unreset; count alone decides validity.
  always_ff @(posedge clk) begin
    if (push && !(rst || flush)) mem[wr_ptr] <= din;
  end

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
endmodule

// File: rtl/syn_fetch_buffer.sv
// Instruction fetch stage: PC register, fetch counter and a decoupling queue to decode.
module syn_fetch_buffer
  import syn_fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   halt,
  input  logic                   redirect,
  input  logic [IM_ADDR_BIT-1:0] redirect_pc,
  output logic [IM_ADDR_BIT-1:0] im_addr,
  input  logic [31:0]            im_inst,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [31:0]            id_inst,
  output logic [IM_ADDR_BIT-1:0] id_pc_4,
  output logic [31:0]            pc_dbg,
  output logic [31:0]            fetch_count
);
  localparam int EW = INST_BITS + IM_ADDR_BIT;

  logic [IM_ADDR_BIT-1:0] pc;
  logic                   full;
  logic                   empty;
  logic [EW-1:0]          head;
  logic                   deq;
  logic                   enq;
  logic                   flush;

  assign deq   = en & id_valid & id_ready;
  assign enq   = en & ~halt & ~redirect & (~full | deq);
  assign flush = en & redirect;

  syn_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (enq),
    .pop   (deq),
    .flush (flush),
    .din   ({im_inst, pc}),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= '0;
      fetch_count <= '0;
    end else begin
      if (flush)    pc <= redirect_pc;
      else if (enq) pc <= pc + 1'b1;
      if (enq) fetch_count <= fetch_count + 32'd1;
    end
  end

  assign im_addr  = pc;
  assign pc_dbg   = {{(30-IM_ADDR_BIT){1'b0}}, pc, 2'b00};
  assign id_valid = ~empty;
  assign id_inst  = empty ? '0 : head[EW-1:IM_ADDR_BIT];
  assign id_pc_4  = empty ? '0 : head[IM_ADDR_BIT-1:0] + 1'b1;
endmodule

// File: doc/syn_fetch_buffer.md
SYN_FETCH_BUFFER -- requirements
Module: syn_fetch_buffer

Interface
REQ-001 Parameter DEPTH, default 2, SHALL be the number of fetch-queue entries; legal values are powers of two, 2 or more.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 en  input  1  global step enable; when 0, all state SHALL hold.
REQ-005 halt  input  1  syscall halt; when 1, new fetches SHALL stop.
REQ-006 redirect  input  1  jump or taken branch resolved downstream.
REQ-007 redirect_pc  input  `IM_ADDR_BIT  word-address target of the redirect.
REQ-008 im_addr  output  `IM_ADDR_BIT  word address presented to the combinational instruction memory; SHALL equal the PC register.
REQ-009 im_inst  input  32  instruction returned by the instruction memory in the same cycle.
REQ-010 id_valid  output  1  head entry is valid for decode.
REQ-011 id_ready  input  1  decode accepts the head entry this cycle.
REQ-012 id_inst  output  32  instruction at the queue head.
REQ-013 id_pc_4  output  `IM_ADDR_BIT  head entry PC+1, as a word address.
REQ-014 pc_dbg  output  32  equal to {20'd0, PC, 2'd0}.
REQ-015 fetch_count  output  32  number of enqueued instructions since reset.

Function
REQ-016 PC SHALL be an `IM_ADDR_BIT-wide word address; increments SHALL wrap modulo 2^`IM_ADDR_BIT.
REQ-017 The queue SHALL be a circular buffer of DEPTH entries holding {inst, pc}, with rd_ptr, wr_ptr and a count field wide enough for the value DEPTH.
REQ-018 deq SHALL equal en & id_valid & id_ready.
REQ-019 enq SHALL equal en & ~halt & ~redirect & (count<DEPTH | deq).
REQ-020 On enq, entry {im_inst, PC} SHALL be written at wr_ptr, wr_ptr SHALL increment, and PC SHALL become PC+1.
REQ-021 On deq, rd_ptr SHALL increment.
REQ-022 count SHALL become count+enq-deq; simultaneous enq and deq when full SHALL leave count equal to DEPTH.
REQ-023 When en & redirect:
  - PC SHALL become redirect_pc.
  - rd_ptr, wr_ptr and count SHALL clear.
  - No enqueue SHALL occur.
  - redirect SHALL have priority over halt, enq and deq.
REQ-024 id_valid SHALL be (count!=0); id_inst and id_pc_4 SHALL be driven combinationally from the rd_ptr entry.
REQ-025 When id_valid=0, id_inst SHALL be 32'd0 (nop) and id_pc_4 SHALL be 0.
REQ-026 Latency: an instruction fetched at edge N SHALL be visible on id_* immediately after edge N. Back-to-back throughput SHALL be one instruction per cycle while id_ready=1.
REQ-027 While halt=1, PC SHALL hold; the queue SHALL still drain through deq.
REQ-028 fetch_count SHALL increment on each enq and wrap at 2^32.
REQ-029 While en=0, no state SHALL change, whatever the other inputs are.

Reset
REQ-030 When rst=1 at a clock edge, the block SHALL set PC=0, rd_ptr=wr_ptr=count=0 and fetch_count=0, overriding en, redirect and all other inputs.
REQ-031 Outputs after reset SHALL be: id_valid=0, id_inst=0, id_pc_4=0, im_addr=0, pc_dbg=0, fetch_count=0.
REQ-032 Reset asserted mid-stream SHALL discard all queued entries with no partial dequeue.
REQ-033 Queue storage contents need no reset.

Structure
REQ-034 `IM_ADDR_BIT SHALL come from Core.vh, the shared constants header.
REQ-035 No new typedefs SHALL be introduced; DEPTH stays a module parameter.
REQ-036 The queue SHALL be one sub-module, syn_fetch_fifo (parameters DEPTH and entry WIDTH), with push, pop, flush, full, empty and head; PC and counter logic SHALL live in syn_fetch_buffer.

Verification
REQ-037 Reset, then en=1, id_ready=1, im_inst=instruction memory word[addr]:
  - -> id_inst sequence equals word[0], word[1], ...
  - -> id_pc_4 = 1, 2, ...
  - -> fetch_count = 5 after 5 cycles.
REQ-038 id_ready=0 for 4 cycles with DEPTH=2:
  - -> count saturates at 2, PC stops at 2, fetch_count = 2.
  - Then id_ready=1 -> one instruction per cycle with no gap.
REQ-039 Queue full, redirect=1 with redirect_pc=0x040 and id_ready=1 in the same cycle -> next cycle:
  - id_valid=0, PC=0x040, pc_dbg=0x100.
  - The following cycle id_inst=word[0x040].
REQ-040 PC=0x3FF (`IM_ADDR_BIT=10), enqueue -> PC wraps to 0x000; entry id_pc_4=0x000.
REQ-041 halt=1 with 2 entries queued -> both drain, then id_valid=0, PC constant, fetch_count constant.
REQ-042 Two edge checks:
  - en=0 with redirect=1 -> no change.
  - rst=1 mid-stream with en=1 -> all REQ-031 values on the next cycle.
